// File: rtl/cmd_frame_gen_if.sv
// Command request and UART-transmitter handshake bundle for cmd_frame_gen.
// The master side is the host plus transmitter. The slave side is the framer.
interface cmd_frame_gen_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_fun;
    logic       tx_busy;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_done;
    logic [7:0] frame_cnt;

    modport master (
        output cmd_valid, cmd_type, cmd_addr, cmd_a, cmd_b, cmd_fun, tx_busy,
        input  cmd_ready, byte_out, byte_valid, frame_done, frame_cnt
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_addr, cmd_a, cmd_b, cmd_fun, tx_busy,
        output cmd_ready, byte_out, byte_valid, frame_done, frame_cnt
    );
endinterface

// File: rtl/cmd_frame_gen.sv
// Expands one latched command request into its frame bytes.
// Each byte is handed to a UART transmitter with a valid/busy handshake.
module cmd_frame_gen #(
    parameter logic [7:0] CMD_AA = 8'hAA,
    parameter logic [7:0] CMD_BB = 8'hBB,
    parameter logic [7:0] CMD_CC = 8'hCC,
    parameter logic [7:0] CMD_DD = 8'hDD
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    cmd_frame_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    localparam logic [1:0] T_RF_WR  = 2'd0;
    localparam logic [1:0] T_RF_RD  = 2'd1;
    localparam logic [1:0] T_ALU_OP = 2'd2;
    localparam logic [1:0] T_ALU_NO = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic [1:0] type_q,  type_d;
    logic [3:0] addr_q,  addr_d;
    logic [7:0] a_q,     a_d;
    logic [7:0] b_q,     b_d;
    logic [3:0] fun_q,   fun_d;
    logic       done_q,  done_d;
    logic [7:0] cnt_q,   cnt_d;

    logic       cmd_ready;
    logic       accept;
    logic [1:0] last_idx;
    logic [7:0] frame_byte;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = bus.cmd_valid && cmd_ready;

    // Index of the final byte: frame length minus one, from the latched type.
    always_comb begin
        case (type_q)
            T_RF_WR:  last_idx = 2'd2;
            T_RF_RD:  last_idx = 2'd1;
            T_ALU_OP: last_idx = 2'd3;
            default:  last_idx = 2'd1;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        frame_byte = 8'h00;
        case (type_q)
            T_RF_WR: begin
                case (idx_q)
                    2'd0:    frame_byte = CMD_AA;
                    2'd1:    frame_byte = {4'h0, addr_q};
                    2'd2:    frame_byte = a_q;
                    default: frame_byte = 8'h00;
                endcase
            end
            T_RF_RD: begin
                case (idx_q)
                    2'd0:    frame_byte = CMD_BB;
                    2'd1:    frame_byte = {4'h0, addr_q};
                    default: frame_byte = 8'h00;
                endcase
            end
            T_ALU_OP: begin
                case (idx_q)
                    2'd0:    frame_byte = CMD_CC;
                    2'd1:    frame_byte = a_q;
                    2'd2:    frame_byte = b_q;
                    default: frame_byte = {4'h0, fun_q};
                endcase
            end
            default: begin
                case (idx_q)
                    2'd0:    frame_byte = CMD_DD;
                    2'd1:    frame_byte = {4'h0, fun_q};
                    default: frame_byte = 8'h00;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        type_d  = type_q;
        addr_d  = addr_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                    idx_d   = 2'd0;
                    type_d  = bus.cmd_type;
                    addr_d  = bus.cmd_addr;
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    fun_d   = bus.cmd_fun;
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (bus.tx_busy) state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // The transmitter has finished this byte. Either the frame ends or the next byte follows.
                if (!bus.tx_busy) begin
                    if (idx_q == last_idx) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            type_q  <= 2'd0;
            addr_q  <= 4'h0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            fun_q   <= 4'h0;
            done_q  <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.byte_valid = (state_q == ST_SEND);
    assign bus.byte_out   = (state_q == ST_SEND) ? frame_byte : 8'h00;
    assign bus.frame_done = done_q;
    assign bus.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_cmd_frame_gen.sv
// Directed bench for cmd_frame_gen: frame contents, handshake timing, reset abort, and counter wrap.
module tb_cmd_frame_gen;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pulses;

    cmd_frame_gen_if bus ();

    cmd_frame_gen dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.byte_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_timeout"}, {31'd0, bus.byte_valid}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] addr,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        check("ready_before_accept", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_type  = t;
        bus.cmd_addr  = addr;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_fun   = fun;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = ~t;
        bus.cmd_addr  = ~addr;
        bus.cmd_a     = ~a;
        bus.cmd_b     = ~b;
        bus.cmd_fun   = ~fun;
        check("ready_after_accept", {31'd0, bus.cmd_ready}, 32'd0);
        check("valid_after_accept", {31'd0, bus.byte_valid}, 32'd1);
        check("done_after_accept", {31'd0, bus.frame_done}, 32'd0);
    endtask

    task automatic xfer(input logic [7:0] exp_byte, input int busy_len);
        wait_valid("xfer");
        check("byte_out", {24'd0, bus.byte_out}, {24'd0, exp_byte});
        @(negedge clk);
        check("valid_after_handoff", {31'd0, bus.byte_valid}, 32'd0);
        check("ready_mid_frame", {31'd0, bus.cmd_ready}, 32'd0);
        bus.tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        bus.tx_busy = 1'b0;
    endtask

    task automatic frame_end(input logic [7:0] exp_cnt);
        @(negedge clk);
        check("frame_done", {31'd0, bus.frame_done}, 32'd1);
        check("ready_after_done", {31'd0, bus.cmd_ready}, 32'd1);
        check("frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, exp_cnt});
        if (bus.frame_done === 1'b1) pulses++;
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("rst_byte", {24'd0, bus.byte_out}, 32'd0);
        check("rst_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_cnt;
        logic [3:0] fun;
        checks = 0;
        errors = 0;
        pulses = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'd0;
        bus.cmd_addr  = 4'h0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_fun   = 4'h0;
        bus.tx_busy   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        // RF write frame, 10-cycle transmitter busy.
        issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
        xfer(8'hAA, 10);
        xfer(8'h05, 10);
        xfer(8'h3C, 10);
        frame_end(8'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.frame_done}, 32'd0);

        // ALU frame with operands; the inputs are scrambled after accept.
        issue(2'd2, 4'h0, 8'h12, 8'h34, 4'h2);
        xfer(8'hCC, 3);
        xfer(8'h12, 3);
        xfer(8'h34, 3);
        xfer(8'h02, 3);
        frame_end(8'd2);

        // RF read then ALU-no-operand, back-to-back in the first idle cycle.
        issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
        xfer(8'hBB, 2);
        xfer(8'h02, 2);
        frame_end(8'd3);
        issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h7);
        xfer(8'hDD, 2);
        xfer(8'h07, 2);
        frame_end(8'd4);

        // Transmitter busy before SEND: the byte is held for 20 cycles.
        @(negedge clk);
        bus.tx_busy = 1'b1;
        issue(2'd1, 4'hA, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < 20; i++) begin
            check("hold_valid", {31'd0, bus.byte_valid}, 32'd1);
            check("hold_byte", {24'd0, bus.byte_out}, 32'h0000_00BB);
            @(negedge clk);
        end
        bus.tx_busy = 1'b0;
        xfer(8'hBB, 2);
        xfer(8'h0A, 2);
        frame_end(8'd5);

        // Reset while byte 2 of an ALU frame is presented.
        issue(2'd2, 4'h0, 8'h5A, 8'hC3, 4'h9);
        xfer(8'hCC, 2);
        xfer(8'h5A, 2);
        wait_valid("pre_reset");
        check("pre_reset_byte", {24'd0, bus.byte_out}, 32'h0000_00C3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        issue(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
        xfer(8'hBB, 2);
        xfer(8'h03, 2);
        frame_end(8'd1);

        // 256 short frames from a fresh reset: the counter wraps to zero.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulses  = 0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            fun = 4'(i);
            exp_cnt = exp_cnt + 8'd1;
            issue(2'd3, 4'h0, 8'h00, 8'h00, fun);
            xfer(8'hDD, 1);
            xfer({4'h0, fun}, 1);
            frame_end(exp_cnt);
        end
        check("wrap_pulses", 32'(pulses), 32'd256);
        check("wrap_cnt", {24'd0, bus.frame_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
